// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 core definitions used by the writeback path.
//   XLEN / REG_TAG_W  - datapath and register-tag widths
//   wb_entry_t        - one buffered writeback (destination tag + data)
//   SRC_ALU/MUL/DIV   - conventional execution-unit source indices
//   tag_writes()      - true when a destination tag really updates the RF
package rv32_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_TAG_W = 5;

    typedef struct packed {
        logic [REG_TAG_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MUL = 1;
    localparam int unsigned SRC_DIV = 2;

    // x0 is hardwired to zero, so results aimed at it are simply discarded.
    function automatic logic tag_writes(input logic [REG_TAG_W-1:0] tag);
        return tag != '0;
    endfunction

endpackage

// File: rtl/wb_result_arbiter_if.sv
// wb_result_arbiter_if: bundle between the execution units and the writeback stage.
//   src_valid/src_result/src_tag - per-source packed result offers
//   src_ready                    - per-source "may present a result" (FIFO not full)
//   wb_valid/wb_rd/wb_data       - register-file write port / scoreboard clear
//   wb_src                       - granted source index
//   idle                         - nothing buffered and no write in flight
// modport slave is the writeback block, modport master the producer/observer side.
interface wb_result_arbiter_if #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned WIDTH   = 32
) ();
    import rv32_pkg::*;

    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC*WIDTH-1:0]     src_result;
    logic [NUM_SRC*REG_TAG_W-1:0] src_tag;
    logic [NUM_SRC-1:0]           src_ready;
    logic                         wb_valid;
    logic [REG_TAG_W-1:0]         wb_rd;
    logic [WIDTH-1:0]             wb_data;
    logic [SRC_W-1:0]             wb_src;
    logic                         idle;

    modport slave (
        input  src_valid, src_result, src_tag,
        output src_ready, wb_valid, wb_rd, wb_data, wb_src, idle
    );

    modport master (
        output src_valid, src_result, src_tag,
        input  src_ready, wb_valid, wb_rd, wb_data, wb_src, idle
    );

endinterface

// File: rtl/wb_src_fifo.sv
// wb_src_fifo: small synchronous FIFO buffering one execution unit's results.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push       - write push_data (ignored when full)
//   push_data  - entry to write
//   pop        - drop the head entry (ignored when empty)
//   full/empty - registered occupancy flags
//   head       - oldest entry, valid when !empty
// Push and pop together below full leave the occupancy unchanged.
module wb_src_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit tells full (wrap bits differ) from empty (equal).
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    logic        do_push, do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: writeback stage behind the execution units.
//   clk, rst - clock, synchronous active-high reset
//   bus      - wb_result_arbiter_if.slave: per-source result offers in, src_ready out,
//              registered RF write port (wb_valid/wb_rd/wb_data/wb_src) and idle out
// Each source feeds its own FIFO; a round-robin arbiter over the non-empty heads pops
// one entry per cycle into the output register. Results tagged x0 are never queued.
module wb_result_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    wb_result_arbiter_if.slave  bus
);

    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [REG_TAG_W-1:0] rd;
        logic [WIDTH-1:0]     data;
    } entry_t;

    logic [NUM_SRC-1:0] push, pop, full, empty;
    entry_t             push_entry [NUM_SRC];
    entry_t             head       [NUM_SRC];

    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;
    entry_t             grant_entry;

    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 wb_valid_q;
    logic [REG_TAG_W-1:0] wb_rd_q;
    logic [WIDTH-1:0]     wb_data_q;
    logic [SRC_W-1:0]     wb_src_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign push_entry[g] = '{
            rd:   bus.src_tag[g*REG_TAG_W +: REG_TAG_W],
            data: bus.src_result[g*WIDTH +: WIDTH]
        };

        // Ready comes from registered occupancy, so gating with !full is the handshake.
        // Inputs seen during reset are ignored.
        assign push[g] = !rst && bus.src_valid[g] && !full[g] && tag_writes(push_entry[g].rd);
        assign pop[g]  = grant_valid && (grant_idx == SRC_W'(g));

        wb_src_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (push_entry[g]),
            .pop       (pop[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .head      (head[g])
        );

        // Offering a result while not ready drops it; the producer broke the protocol.
        a_no_push_when_full : assert property (
            @(posedge clk) disable iff (rst) !(bus.src_valid[g] && full[g])
        ) else $error("wb_result_arbiter: source %0d valid while not ready", g);
    end

    // Round-robin: first non-empty head at or after the pointer, with wrap-around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_entry = head[grant_idx];
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_src_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= grant_valid;
            // rd/data/src hold their last write when nothing is granted.
            if (grant_valid) begin
                wb_rd_q   <= grant_entry.rd;
                wb_data_q <= grant_entry.data;
                wb_src_q  <= grant_idx;
            end
        end
    end

    assign bus.src_ready = ~full;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_src    = wb_src_q;
    assign bus.idle      = (&empty) && !wb_valid_q;

endmodule

// File: tb/tb_wb_result_arbiter.sv
// tb_wb_result_arbiter: scenario tasks for the writeback arbiter. Accepted results are
// pushed to per-source expected queues when driven; a negedge monitor pops and
// compares them whenever wb_valid is seen.
module tb_wb_result_arbiter;

    localparam int NS = 3;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_result_arbiter_if #(.NUM_SRC(NS), .WIDTH(W)) bus ();

    wb_result_arbiter #(
        .NUM_SRC    (NS),
        .WIDTH      (W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [36:0] exp_q    [NS][$];
    logic [31:0] data_log [NS][$];
    logic [1:0]  grant_log[$];

    // Monitor: every write must match the oldest outstanding result of its source.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            logic [36:0] e;
            grant_log.push_back(bus.wb_src);
            total++;
            if (bus.wb_src >= 2'(NS) || exp_q[bus.wb_src].size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got src=%0d rd=%0d data=%h, expected no write",
                         bus.wb_src, bus.wb_rd, bus.wb_data);
            end else begin
                data_log[bus.wb_src].push_back(bus.wb_data);
                e = exp_q[bus.wb_src].pop_front();
                if ({bus.wb_rd, bus.wb_data} !== e) begin
                    bad++;
                    $display("FAIL wb_entry src%0d: got rd=%0d data=%h, expected rd=%0d data=%h",
                             bus.wb_src, bus.wb_rd, bus.wb_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers only where ready is high, and records what the DUT must write back.
    task automatic drive(input logic [2:0] v, input logic [4:0] t0, t1, t2,
                         input logic [31:0] d0, d1, d2);
        logic [2:0] m;
        m = v & bus.src_ready;
        bus.src_valid  = m;
        bus.src_tag    = {t2, t1, t0};
        bus.src_result = {d2, d1, d0};
        if (!rst) begin
            if (m[0] && t0 != 5'd0) exp_q[0].push_back({t0, d0});
            if (m[1] && t1 != 5'd0) exp_q[1].push_back({t1, d1});
            if (m[2] && t2 != 5'd0) exp_q[2].push_back({t2, d2});
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) begin
            exp_q[i].delete();
            data_log[i].delete();
        end
        grant_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.idle !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (bus.idle !== 1'b1) begin
            bad++;
            $display("FAIL drain_timeout: idle=%b after %0d cycles, expected 1", bus.idle, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        total += 6;
        if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid: got %b, expected 0", bus.wb_valid); end
        if (bus.wb_rd !== 5'd0) begin bad++; $display("FAIL rst_wb_rd: got %0d, expected 0", bus.wb_rd); end
        if (bus.wb_data !== 32'd0) begin bad++; $display("FAIL rst_wb_data: got %h, expected 0", bus.wb_data); end
        if (bus.wb_src !== 2'd0) begin bad++; $display("FAIL rst_wb_src: got %0d, expected 0", bus.wb_src); end
        if (bus.idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b, expected 1", bus.idle); end
        if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL rst_ready: got %b, expected 111", bus.src_ready); end
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_lone();
        drive(3'b010, 0, 5, 0, 0, 32'h0000_1234, 0);
        tick();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        total += 2;
        if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL lone_early: wb_valid=%b, expected 0", bus.wb_valid); end
        if (bus.idle !== 1'b0) begin bad++; $display("FAIL lone_busy: idle=%b, expected 0", bus.idle); end
        tick();
        total += 4;
        if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL lone_valid: got %b, expected 1", bus.wb_valid); end
        if (bus.wb_rd !== 5'd5) begin bad++; $display("FAIL lone_rd: got %0d, expected 5", bus.wb_rd); end
        if (bus.wb_data !== 32'h1234) begin bad++; $display("FAIL lone_data: got %h, expected 1234", bus.wb_data); end
        if (bus.wb_src !== 2'd1) begin bad++; $display("FAIL lone_src: got %0d, expected 1", bus.wb_src); end
        tick();
        total += 3;
        if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL lone_pulse: wb_valid=%b, expected 0", bus.wb_valid); end
        if (bus.idle !== 1'b1) begin bad++; $display("FAIL lone_idle: got %b, expected 1", bus.idle); end
        if (bus.wb_rd !== 5'd5) begin bad++; $display("FAIL lone_hold_rd: got %0d, expected 5", bus.wb_rd); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_src [3];
        logic [4:0] exp_rd  [3];
        exp_src = '{2'd0, 2'd1, 2'd2};
        exp_rd  = '{5'd1, 5'd2, 5'd3};
        do_reset();
        drive(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC);
        tick();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total += 3;
            if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL cont_valid[%0d]: got %b, expected 1", i, bus.wb_valid); end
            if (bus.wb_src !== exp_src[i]) begin bad++; $display("FAIL cont_src[%0d]: got %0d, expected %0d", i, bus.wb_src, exp_src[i]); end
            if (bus.wb_rd !== exp_rd[i]) begin bad++; $display("FAIL cont_rd[%0d]: got %0d, expected %0d", i, bus.wb_rd, exp_rd[i]); end
        end
        tick();
        total++;
        if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL cont_end: wb_valid=%b, expected 0", bus.wb_valid); end
        // Pointer should have wrapped back to 0: next three-way burst starts at src0.
        drive(3'b111, 4, 5, 6, 32'h1, 32'h2, 32'h3);
        tick();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (bus.wb_src !== 2'd0) begin bad++; $display("FAIL cont_ptr_wrap: got src %0d, expected 0", bus.wb_src); end
        wait_idle();
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(3'b101, 10, 0, 20, 32'h1000 + i, 0, 32'h2000 + i);
            tick();
        end
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        wait_idle();
        total++;
        if (grant_log.size() < 18) begin
            bad++;
            $display("FAIL fair_count: got %0d grants, expected at least 18", grant_log.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                logic [1:0] e;
                e = (i % 2 == 0) ? 2'd0 : 2'd2;
                total++;
                if (grant_log[i] !== e) begin
                    bad++;
                    $display("FAIL fair_order[%0d]: got src %0d, expected %0d", i, grant_log[i], e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(3'b011, 7, 9, 0, 32'h100, 32'h11, 0);
        tick();
        total++;
        if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL bp_ready1: got %b, expected 111", bus.src_ready); end
        drive(3'b011, 7, 9, 0, 32'h101, 32'h22, 0);
        tick();
        // src1 now full; it is popped at the next edge but ready must stay low this cycle.
        total += 3;
        if (bus.src_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_full: src_ready[1]=%b, expected 0", bus.src_ready[1]); end
        if (bus.wb_src !== 2'd0) begin bad++; $display("FAIL bp_grant0: got src %0d, expected 0", bus.wb_src); end
        if (bus.wb_data !== 32'h100) begin bad++; $display("FAIL bp_data0: got %h, expected 100", bus.wb_data); end
        drive(3'b001, 7, 0, 0, 32'h102, 0, 0);
        tick();
        total += 3;
        if (bus.wb_src !== 2'd1) begin bad++; $display("FAIL bp_grant1: got src %0d, expected 1", bus.wb_src); end
        if (bus.wb_data !== 32'h11) begin bad++; $display("FAIL bp_data1: got %h, expected 11", bus.wb_data); end
        if (bus.src_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_reready: src_ready[1]=%b, expected 1", bus.src_ready[1]); end
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        wait_idle();
        total++;
        if (data_log[1].size() != 2) begin
            bad++;
            $display("FAIL bp_src1_count: got %0d writes, expected 2", data_log[1].size());
        end else begin
            total++;
            if (data_log[1][0] !== 32'h11 || data_log[1][1] !== 32'h22) begin
                bad++;
                $display("FAIL bp_order: got %h,%h, expected 11,22", data_log[1][0], data_log[1][1]);
            end
        end
    endtask

    task automatic test_x0();
        drive(3'b001, 0, 0, 0, 32'hDEAD, 0, 0);
        tick();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total += 2;
            if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL x0_write[%0d]: wb_valid=%b, expected 0", i, bus.wb_valid); end
            if (bus.idle !== 1'b1) begin bad++; $display("FAIL x0_idle[%0d]: idle=%b, expected 1", i, bus.idle); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(3'b111, 1, 2, 3, 32'h51, 32'h52, 32'h53);
        tick();
        drive(3'b111, 4, 5, 6, 32'h61, 32'h62, 32'h63);
        tick();
        rst = 1'b1;
        drive(3'b111, 7, 8, 9, 32'h71, 32'h72, 32'h73);
        tick();
        rst = 1'b0;
        clear_model();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        total += 3;
        if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL mid_wb_valid: got %b, expected 0", bus.wb_valid); end
        if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL mid_ready: got %b, expected 111", bus.src_ready); end
        if (bus.idle !== 1'b1) begin bad++; $display("FAIL mid_idle: got %b, expected 1", bus.idle); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL mid_flushed[%0d]: wb_valid=%b, expected 0", i, bus.wb_valid); end
        end
        // src1 and src2 together: pointer back at 0 means src1 wins first.
        drive(3'b110, 0, 5, 6, 0, 32'h1234, 32'h5678);
        tick();
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        total += 3;
        if (bus.wb_src !== 2'd1) begin bad++; $display("FAIL mid_ptr: got src %0d, expected 1", bus.wb_src); end
        if (bus.wb_rd !== 5'd5) begin bad++; $display("FAIL mid_rd: got %0d, expected 5", bus.wb_rd); end
        if (bus.wb_data !== 32'h1234) begin bad++; $display("FAIL mid_data: got %h, expected 1234", bus.wb_data); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_lone();
        test_contention();
        test_fairness();
        test_backpressure();
        test_x0();
        test_reset_mid();
        tick();
        total++;
        if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d results never written, expected 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_result_arbiter.md
Name: wb_result_arbiter

Overview:
Writeback stage downstream of the execution units (ALU, multiplier, divider). Each unit delivers a tagged result, which the block buffers in a small per-source FIFO. A round-robin arbiter then picks one result per cycle. The winner drives the single register-file write port and the scoreboard clear.

Parameters:
NUM_SRC, 3, number of execution-unit result sources (index 0 = ALU, 1 = MUL, 2 = DIV by convention)
WIDTH, 32, result data width
FIFO_DEPTH, 2, entries per source FIFO (power of 2, >= 2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
src_valid  input  NUM_SRC  per-source result valid
src_result  input  NUM_SRC*WIDTH  packed results, source i at [i*WIDTH +: WIDTH]
src_tag  input  NUM_SRC*5  packed destination register tags, source i at [i*5 +: 5]
src_ready  output  NUM_SRC  source i may present a result this cycle
wb_valid  output  1  register-file write enable / scoreboard clear strobe
wb_rd  output  5  destination register
wb_data  output  WIDTH  write data
wb_src  output  $clog2(NUM_SRC)  index of the granted source (debug/perf)
idle  output  1  all FIFOs empty and no write in flight

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: wb_valid=0, wb_rd=0, wb_data=0, wb_src=0, idle=1, src_ready=all 1. All FIFOs empty; round-robin pointer=0.
- Enqueue:
  - Source i is accepted at a rising edge when src_valid[i] && src_ready[i].
  - src_valid[i] while src_ready[i]=0 is a protocol violation; the result is dropped and a simulation assertion fires.
- Tag 0 (x0): accepted, never stored, never written. src_ready is unaffected.
- src_ready[i] = FIFO i not full, based on registered occupancy only. A pop in the same cycle does not raise ready (no full-FIFO pass-through).
- A FIFO supports simultaneous push and pop at any occupancy below full. Occupancy is unchanged in that case.
- Arbitration:
  - Combinational over non-empty FIFO heads.
  - Search starts at the pointer and proceeds in increasing index with wrap-around.
  - On a grant, the pointer moves to (granted index + 1) mod NUM_SRC. With no grant, the pointer holds.
- Output register:
  - On each edge, the granted head is popped into wb_rd/wb_data/wb_src and wb_valid=1.
  - With no grant, wb_valid=0; wb_rd/wb_data hold their previous values.
  - wb_valid is a single-cycle strobe per result.
- Latency:
  - A result accepted at edge E with no contention is visible at the outputs from edge E+1 (one-cycle pulse).
  - Under contention, extra delay is bounded by NUM_SRC-1 cycles per queued entry ahead of it.
- Per-source ordering is strictly FIFO. Cross-source ordering is not guaranteed.
- Two sources carrying the same rd are not checked (the scoreboard prevents this). Both are written, in grant order.
- Throughput: exactly one write per cycle when any FIFO is non-empty.
- idle = all FIFOs empty && wb_valid==0.
- rst asserted mid-operation:
  - All FIFO contents are discarded (no writeback for them) at that edge.
  - Inputs presented in the reset cycle are ignored.
  - Outputs take reset values at that edge.

Decomposition:
- Shared package rv32_pkg holds:
  - XLEN=32 and REG_TAG_W=5;
  - wb_entry_t struct {logic [4:0] rd; logic [XLEN-1:0] data;};
  - the source-index constants SRC_ALU=0, SRC_MUL=1, SRC_DIV=2.
- One sub-module, wb_src_fifo, is instantiated NUM_SRC times.
  - It is a synchronous FIFO with parameters DEPTH and entry type.
  - Ports: push, pop, full, empty, head.
  - Pointers are one bit wider than the index for full/empty.
- The arbiter, pointer and output register stay in wb_result_arbiter.

Test Plan:
1. Lone result: src_valid=3'b010, tag=5, result=0x0000_1234 at edge E -> wb_valid=1, wb_rd=5, wb_data=0x1234, wb_src=1 for exactly one cycle starting at E+1; idle=1 after.
2. Three-way contention: all sources valid on one edge with tags 1/2/3, data 0xA/0xB/0xC, pointer=0 -> writes occur on three consecutive cycles in order src0, src1, src2; pointer ends at 0.
3. Fairness: src0 and src2 valid every cycle (whenever ready) for 20 cycles -> grants alternate 0,2,0,2…; neither source waits more than 1 cycle between grants.
4. Backpressure: stall arbitration by keeping src0 busy; push 2 results into src1 -> src_ready[1]=0 after the second; a pop and push in the same cycle on the full FIFO is not accepted; FIFO order is preserved (data 0x11 then 0x22).
5. x0 drop: src0 valid, tag=0, data=0xDEAD -> no wb_valid ever for it; idle stays 1.
6. Reset mid-operation: fill all FIFOs, assert rst for one cycle -> wb_valid=0 from that edge, no queued result is ever written, src_ready=3'b111, next lone result behaves as in test 1 with wb_src chosen from pointer 0.
